// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bit counter width; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done request bus of the serial adder; ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  sum, cout, busy, done
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, busy, done
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational full adder cell, the single arithmetic element of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Optional signed overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int             CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q, sum_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry, cout_q;
  logic             s, co;
  logic             accept, last;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = s;
    end else begin : g_wn
      assign sum_nxt = {s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      carry  <= bus.cin;
      cnt    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (state == RUN) begin
      sum_q <= sum_nxt;
      carry <= co;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        cout_q <= co;
`ifdef SERIAL_ADD_OVF_EN
        // Carry into the MSB differing from carry out means signed overflow.
        ovf_q  <= carry ^ co;
`endif
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accept edge on the 8-bit DUT and releases start.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    tick();
    bus8.start = 1'b0;
  endtask

  // Counts edges until done, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done8(input string tag, input int exp_edges);
    int n = 0;
    while (!bus8.done && n < 20) begin
      tick();
      n++;
    end
    check(tag, n, exp_edges);
  endtask

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    #12;
    check("rst_sum",  bus8.sum,  8'h00);
    check("rst_cout", bus8.cout, 1'b0);
    check("rst_busy", bus8.busy, 1'b0);
    check("rst_done", bus8.done, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf",  bus8.ovf,  1'b0);
`endif
    rst = 1'b0;
    tick();

    // FF + 01: full carry ripple
    start_op8(8'hFF, 8'h01, 1'b0);
    check("t1_busy", bus8.busy, 1'b1);
    wait_done8("t1_lat", 8);
    check("t1_sum",  bus8.sum,  8'h00);
    check("t1_cout", bus8.cout, 1'b1);
    tick();
    check("t1_pulse", bus8.done, 1'b0);
    check("t1_idle",  bus8.busy, 1'b0);
    check("t1_hold",  bus8.sum,  8'h00);

`ifdef SERIAL_ADD_OVF_EN
    start_op8(8'h5A, 8'h25, 1'b1);
    wait_done8("t2a_lat", 8);
    check("t2a_sum",  bus8.sum,  8'h80);
    check("t2a_cout", bus8.cout, 1'b0);
    check("t2a_ovf",  bus8.ovf,  1'b1);
    tick();
    start_op8(8'h80, 8'hFF, 1'b0);
    check("t2b_clr",  bus8.ovf,  1'b0);
    wait_done8("t2b_lat", 8);
    check("t2b_sum",  bus8.sum,  8'h7F);
    check("t2b_cout", bus8.cout, 1'b1);
    check("t2b_ovf",  bus8.ovf,  1'b1);
    tick();
`endif

    // start during RUN must not disturb the operation
    start_op8(8'h03, 8'h04, 1'b0);
    tick();
    tick();
    bus8.start = 1'b1; bus8.a = 8'h11;
    tick();
    bus8.start = 1'b0; bus8.a = 8'h00;
    wait_done8("t3_lat", 5);
    check("t3_sum",   bus8.sum,  8'h07);
    check("t3_cout",  bus8.cout, 1'b0);
    tick();
    check("t3_pulse", bus8.done, 1'b0);
    check("t3_idle",  bus8.busy, 1'b0);

    // asynchronous reset in the middle of RUN
    start_op8(8'hC8, 8'h64, 1'b0);
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("t4_sum",  bus8.sum,  8'h00);
    check("t4_cout", bus8.cout, 1'b0);
    check("t4_busy", bus8.busy, 1'b0);
    check("t4_done", bus8.done, 1'b0);
    tick();
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus8.done) seen++;
      end
      check("t4_nodone", seen, 0);
    end
    start_op8(8'hC8, 8'h64, 1'b0);
    wait_done8("t4_lat", 8);
    check("t4_sum2",  bus8.sum,  8'h2C);
    check("t4_cout2", bus8.cout, 1'b1);
    tick();

    // start held high: second op accepted straight out of DONE
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
    tick();
    bus8.a = 8'h01; bus8.b = 8'h01;
    wait_done8("t5a_lat", 8);
    check("t5a_sum", bus8.sum, 8'h30);
    tick();
    bus8.start = 1'b0;
    check("t5_gap_done", bus8.done, 1'b0);
    check("t5_gap_busy", bus8.busy, 1'b1);
    wait_done8("t5b_lat", 8);
    check("t5b_sum",  bus8.sum,  8'h02);
    check("t5b_cout", bus8.cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check("t5b_ovf",  bus8.ovf,  1'b0);
`endif
    tick();

    // single-bit adder
    bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("t6_busy", bus1.busy, 1'b1);
    check("t6_early", bus1.done, 1'b0);
    tick();
    check("t6_done", bus1.done, 1'b1);
    check("t6_sum",  bus1.sum,  1'b1);
    check("t6_cout", bus1.cout, 1'b1);
    tick();
    check("t6_pulse", bus1.done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
